// File: rtl/tb_param_pkg.sv
// Shared constants and types for the APB memory arbiter.
// Default widths, requester count, timeout and FSM state enum.
package tb_param_pkg;

  localparam int param_WIDTH_ADDR    = 16;
  localparam int param_WIDTH_DATA    = 32;
  localparam int APB_ARB_NUM_REQ     = 2;
  localparam int APB_ARB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  // Pointer that follows grant g, wrapping at n.
  function automatic int rr_next(
    input int g,
    input int n
  );
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req_i, ptr_i in; grant_o (index), any_req_o out.
module apb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       any_req_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  // Rotate so bit 0 is the requester at ptr; off is its
  // distance to the first pending requester.
  assign rot = NUM_REQ'({req_i, req_i} >> ptr_i);

  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
  end

  assign sum = {1'b0, ptr_i} + {1'b0, off};

  assign grant_o =
    (sum >= (IW+1)'(NUM_REQ)) ?
    IW'(sum - (IW+1)'(NUM_REQ)) :
    sum[IW-1:0];

  assign any_req_o = |req_i;

endmodule

// File: rtl/apb_mem_arbiter.sv
// Round-robin APB master sharing one APB slave among NUM_REQ requesters.
// Ports: req_* valid/ready channel in, rsp_* strobes out, APB master bus.
module apb_mem_arbiter
  import tb_param_pkg::*;
#(
  parameter int NUM_REQ     = APB_ARB_NUM_REQ,
  parameter int ADDR_W      = param_WIDTH_ADDR,
  parameter int DATA_W      = param_WIDTH_DATA,
  parameter int TIMEOUT_CYC = APB_ARB_TIMEOUT_CYC
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam int WCW =
    TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Abort fires on the low-PREADY sample that
  // would bring the count up to TIMEOUT_CYC.
  localparam logic [WCW-1:0] WLAST =
    WCW'(TO_EN ? TIMEOUT_CYC - 1 : 0);

  apb_arb_state_e state_q;

  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      rr_ptr_d;
  logic [IW-1:0]      gnt_q;
  logic [WCW-1:0]     wait_cnt_q;
  logic [IW-1:0]      pick_gnt;
  logic               pick_any;

  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic               psel_q;
  logic               penable_q;
  logic               pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;

  apb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .grant_o   (pick_gnt),
    .any_req_o (pick_any)
  );

  assign rr_ptr_d =
    IW'(rr_next(int'(pick_gnt), NUM_REQ));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      wait_cnt_q  <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      // Strobes are single-cycle unless set below.
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q       <= pick_gnt;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= '0;
            req_ready_q <= NUM_REQ'(1) << pick_gnt;
            // The APB bus registers double as the
            // latched request; held until completion.
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= req_write[pick_gnt];
            paddr_q     <=
              req_addr[pick_gnt*ADDR_W +: ADDR_W];
            pwdata_q    <=
              req_wdata[pick_gnt*DATA_W +: DATA_W];
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_valid_q <= NUM_REQ'(1) << gnt_q;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            state_q     <= IDLE;
          end else if (TO_EN &&
                       wait_cnt_q == WLAST) begin
            rsp_valid_q <= NUM_REQ'(1) << gnt_q;
            rsp_err_q   <= 1'b1;
            wait_cnt_q  <= wait_cnt_q + WCW'(1);
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            state_q     <= IDLE;
          end else if (TO_EN) begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: doc/apb_mem_arbiter.md
# apb_mem_arbiter

Round-robin APB master that lets NUM_REQ requesters share a single APB memory slave port. Each requester submits a read or write on a simple valid/ready request channel. The block grants one requester and runs the APB SETUP/ACCESS sequence on PSEL/PENABLE/PWRITE/PADDR/PWDATA. It then returns PRDATA, or a timeout error, on a per-requester response strobe. It sits between the memory-model clients and the APB-wrapped memory designs.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, param_WIDTH_ADDR: APB address width.
- DATA_W, param_WIDTH_DATA: APB data width.
- TIMEOUT_CYC, 16: maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  system clock; one clock domain only.
- PRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid only while any rsp_valid bit is high.
- rsp_err  out  1  timeout flag; qualified by rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB controls.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB slave ready.

## Operation
Request channel rules:
- A requester holds req_valid, req_write, req_addr and req_wdata stable until it sees req_ready.
- A requester must not deassert req_valid before it sees req_ready.

FSM states: IDLE, SETUP, ACCESS.
- IDLE, with no req_valid bit set: stay in IDLE.
- IDLE, with any req_valid bit set:
  - Pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch grant index, write, addr and wdata.
  - Pulse req_ready[grant].
  - Set rr_ptr = grant+1, wrapping to 0.
  - Go to SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latched values. Always go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: set rsp_valid[grant]=1, rsp_err=0, rsp_rdata = PRDATA for reads or 0 for writes. Go to IDLE.
  - PREADY=0: increment wait_cnt.
  - wait_cnt reaching TIMEOUT_CYC (when nonzero): set rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0. Drop PSEL/PENABLE. Go to IDLE.
- wait_cnt: width $clog2(TIMEOUT_CYC+1); cleared on entry to SETUP.

Bus and arbitration invariants:
- PADDR, PWRITE and PWDATA are held constant from SETUP through the completing ACCESS cycle.
- Only one transfer is in flight at any time.
- A request that arrives during SETUP or ACCESS waits for the next IDLE arbitration.
- Fairness: each continuously-valid requester is granted at least once every NUM_REQ grants.

## Timing
- All outputs are registered. In IDLE the outputs are PSEL=PENABLE=PWRITE=0 and PADDR=PWDATA=0; the latched fields keep their values.
- Reset value of every output is 0. Reset also sets state=IDLE, rr_ptr=0 and wait_cnt=0.
- Reset asserted mid-transfer aborts the transfer immediately: PSEL drops asynchronously and no rsp_valid is produced.
- Clock-edge sequence, with E0 the edge that samples req_valid in IDLE:
  - E0 enters SETUP; req_ready is high for that cycle.
  - E1 enters ACCESS.
  - The first edge that samples PREADY=1 in ACCESS produces rsp_valid in the following cycle.
- Zero-wait transfer: rsp_valid is high 3 cycles after E0. Back-to-back throughput is one transfer per 3 cycles.
- rsp_valid and req_ready are single-cycle pulses that are never held.
- Timeout: with PREADY held low, the abort occurs after exactly TIMEOUT_CYC ACCESS cycles.
- Simultaneous requests arriving at E0 are resolved only by rr_ptr. A lower index gets no priority.

## Structure
- Shared package tb_param_pkg gains the state enum apb_arb_state_e {IDLE, SETUP, ACCESS} and default constants for NUM_REQ and TIMEOUT_CYC.
- Sub-module apb_rr_pick: combinational round-robin picker with inputs req[NUM_REQ] and ptr, outputs grant index and any_req. Instantiated once.
- rr_ptr update and the FSM live in apb_mem_arbiter.

## Test plan
- Single write, zero-wait slave: req0 write addr 0x10, data 0xA5 -> req_ready[0] at E0, PSEL at E0, PENABLE at E1, rsp_valid[0] 3 cycles after E0 with rsp_err=0.
- Single read, 2 wait states: slave returns 0x3C after PREADY is low 2 cycles -> PSEL held for 4 cycles, rsp_rdata=0x3C, rsp_valid[1] 5 cycles after E0.
- Contention: req0 and req1 held continuously from reset -> grants alternate 0,1,0,1, one transfer per 3 cycles, PADDR never changes mid-transfer.
- Timeout: TIMEOUT_CYC=4, PREADY tied low -> abort after 4 ACCESS cycles, rsp_valid with rsp_err=1 and rsp_rdata=0, FSM returns to IDLE, next request is served normally.
- Reset mid-ACCESS: PRESETn driven low during wait states -> PSEL/PENABLE go to 0 without waiting for a PCLK edge, no rsp_valid, first grant after release goes to req0.
